// File: rtl/mem_stage_lsu_if.sv
// Memory request/response bus between the MEM stage LSU and the data memory.
// The request channel is valid/ready; the response channel is valid-only.
interface mem_stage_lsu_if #(
    parameter int XLEN = 64
) ();
    logic                mem_valid;
    logic                mem_ready;
    logic                mem_req;
    logic [XLEN-1:0]     mem_addr;
    logic [1:0]          mem_size;
    logic [XLEN-1:0]     mem_data_write;
    logic [XLEN/8-1:0]   mem_wstrb;
    logic                mem_rsp_valid;
    logic [XLEN-1:0]     mem_data_read;
    logic [1:0]          mem_resp;

    modport master (
        output mem_valid, mem_req, mem_addr, mem_size, mem_data_write, mem_wstrb,
        input  mem_ready, mem_rsp_valid, mem_data_read, mem_resp
    );

    modport slave (
        input  mem_valid, mem_req, mem_addr, mem_size, mem_data_write, mem_wstrb,
        output mem_ready, mem_rsp_valid, mem_data_read, mem_resp
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: latches the EX payload, issues one load/store on the
// memory bus, aligns store data/strobes, extends load data and holds the
// result for WB. Misaligned/illegal accesses complete without a bus request.
module mem_stage_lsu #(
    parameter int                 XLEN     = 64,
    parameter int                 INST_W   = 32,
    parameter logic [INST_W-1:0]  NOP_INST = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               es_to_ms_valid,
    output logic               ms_allowin,
    input  logic [XLEN-1:0]    es_pc,
    input  logic [INST_W-1:0]  es_inst,
    input  logic [4:0]         es_rd,
    input  logic               es_reg_wen,
    input  logic [1:0]         es_wreg_sel,
    input  logic [2:0]         es_func3,
    input  logic               es_mem_ren,
    input  logic               es_mem_wen,
    input  logic [XLEN-1:0]    es_alu_result,
    input  logic [XLEN-1:0]    es_src2,
    input  logic               ws_allowin,
    output logic               ms_to_ws_valid,
    output logic [XLEN-1:0]    ms_pc,
    output logic [INST_W-1:0]  ms_inst,
    output logic [4:0]         ms_rd,
    output logic               ms_reg_wen,
    output logic [1:0]         ms_wreg_sel,
    output logic [XLEN-1:0]    ms_alu_result,
    output logic [XLEN-1:0]    ms_rdata,
    output logic [1:0]         ms_exc,
    mem_stage_lsu_if.master    mem
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e state_r;
    state_e next_state_s;
    state_e accept_state_s;

    logic              accept_s;
    logic              es_is_mem_s;
    logic              es_bad_s;
    logic [1:0]        es_size_s;
    logic [XLEN-1:0]   src2_r;
    logic [2:0]        func3_r;
    logic              wen_r;
    logic [OFF_W-1:0]  off_r;

    // Nonzero low address bits for the access size means misaligned.
    function automatic logic is_misaligned(input logic [2:0] addr_lo, input logic [1:0] size);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr_lo[0];
            2'd2:    bad = |addr_lo[1:0];
            2'd3:    bad = |addr_lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte strobes covering 2^size bytes starting at lane 'off'.
    function automatic logic [STRB_W-1:0] lane_strobe(input logic [OFF_W-1:0] off, input logic [1:0] size);
        logic [STRB_W-1:0] strb;
        int unsigned       lo;
        int unsigned       hi;
        lo = 32'(off);
        hi = lo + (32'd1 << size);
        for (int unsigned i = 0; i < STRB_W; i++) begin
            strb[i] = (i >= lo) && (i < hi);
        end
        return strb;
    endfunction

    // Sign- or zero-extend the low bytes of an already lane-shifted read word.
    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] d, input logic [2:0] f3);
        logic [XLEN-1:0] r;
        case (f3)
            3'd0:    r = XLEN'($signed(d[7:0]));
            3'd1:    r = XLEN'($signed(d[15:0]));
            3'd2:    r = XLEN'($signed(d[31:0]));
            3'd4:    r = XLEN'(d[7:0]);
            3'd5:    r = XLEN'(d[15:0]);
            3'd6:    r = XLEN'(d[31:0]);
            default: r = d;
        endcase
        return r;
    endfunction

    assign es_size_s   = es_func3[1:0];
    assign es_is_mem_s = es_mem_ren || es_mem_wen;
    assign es_bad_s    = es_is_mem_s &&
                         (is_misaligned(es_alu_result[2:0], es_size_s) ||
                          ((es_size_s == 2'd3) && (XLEN == 32)));
    assign accept_state_s = (es_is_mem_s && !es_bad_s) ? REQ : DONE;

    assign ms_allowin     = (state_r == IDLE) || ((state_r == DONE) && ws_allowin);
    assign accept_s       = es_to_ms_valid && ms_allowin;
    assign ms_to_ws_valid = (state_r == DONE);

    assign off_r = ms_alu_result[OFF_W-1:0];

    // Request channel is only non-zero while a request is outstanding.
    assign mem.mem_valid      = (state_r == REQ);
    assign mem.mem_req        = (state_r == REQ) ? wen_r : 1'b0;
    assign mem.mem_addr       = (state_r == REQ) ? ms_alu_result : {XLEN{1'b0}};
    assign mem.mem_size       = (state_r == REQ) ? func3_r[1:0] : 2'b00;
    assign mem.mem_data_write = (state_r == REQ) ? (src2_r << {off_r, 3'b000}) : {XLEN{1'b0}};
    assign mem.mem_wstrb      = (state_r == REQ) ? lane_strobe(off_r, func3_r[1:0]) : {STRB_W{1'b0}};

    // State register; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = accept_state_s;
                else          next_state_s = IDLE;
            end
            REQ: begin
                if (mem.mem_ready) next_state_s = RSP;
                else               next_state_s = REQ;
            end
            RSP: begin
                if (mem.mem_rsp_valid) next_state_s = DONE;
                else                   next_state_s = RSP;
            end
            DONE: begin
                if (accept_s)        next_state_s = accept_state_s;
                else if (ws_allowin) next_state_s = IDLE;
                else                 next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Payload latch, response capture and clear-to-empty when WB drains us.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_pc         <= {XLEN{1'b0}};
            ms_inst       <= NOP_INST;
            ms_rd         <= 5'd0;
            ms_reg_wen    <= 1'b0;
            ms_wreg_sel   <= 2'd0;
            ms_alu_result <= {XLEN{1'b0}};
            ms_rdata      <= {XLEN{1'b0}};
            ms_exc        <= 2'b00;
            src2_r        <= {XLEN{1'b0}};
            func3_r       <= 3'd0;
            wen_r         <= 1'b0;
        end else if (accept_s) begin
            ms_pc         <= es_pc;
            ms_inst       <= es_inst;
            ms_rd         <= es_rd;
            ms_reg_wen    <= es_reg_wen && !es_bad_s;
            ms_wreg_sel   <= es_wreg_sel;
            ms_alu_result <= es_alu_result;
            ms_rdata      <= {XLEN{1'b0}};
            ms_exc        <= {1'b0, es_bad_s};
            src2_r        <= es_src2;
            func3_r       <= es_func3;
            wen_r         <= es_mem_wen;
        end else if ((state_r == RSP) && mem.mem_rsp_valid) begin
            if (mem.mem_resp != 2'b00) begin
                ms_exc[1]  <= 1'b1;
                ms_rdata   <= {XLEN{1'b0}};
                ms_reg_wen <= 1'b0;
            end else if (!wen_r) begin
                ms_rdata <= load_extend(mem.mem_data_read >> {off_r, 3'b000}, func3_r);
            end else begin
                ms_rdata <= {XLEN{1'b0}};
            end
        end else if ((state_r == DONE) && ws_allowin) begin
            ms_pc         <= {XLEN{1'b0}};
            ms_inst       <= NOP_INST;
            ms_rd         <= 5'd0;
            ms_reg_wen    <= 1'b0;
            ms_wreg_sel   <= 2'd0;
            ms_alu_result <= {XLEN{1'b0}};
            ms_rdata      <= {XLEN{1'b0}};
            ms_exc        <= 2'b00;
            src2_r        <= {XLEN{1'b0}};
            func3_r       <= 3'd0;
            wen_r         <= 1'b0;
        end
    end

endmodule
